// File: rtl/ifu.sv
// Instruction fetch unit: keeps one ROM read in flight, buffers returned words in a
// small {pc,instr} FIFO and discards stale data across branch redirects.
module ifu #(
    parameter int          DEPTH    = 4,
    parameter logic [16:0] RESET_PC = 17'h00000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        rom_req,
    output logic [16:0] rom_addr,
    input  logic        rom_ack,
    input  logic [31:0] rom_data,
    output logic [31:0] raw,
    output logic [16:0] raw_pc,
    output logic        valid,
    input  logic        ready,
    input  logic        redir,
    input  logic [16:0] redir_pc,
    output logic        busy
);

    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]  CNT_ONE  = (PTR_W+1)'(1);

    typedef enum logic [1:0] {IDLE, FETCH, DROP} state_t;

    state_t             state_reg, state_next;
    logic [16:0]        addr_reg, addr_next;
    logic [16:0]        fp_reg, fp_next;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     count_reg, count_next;
    logic [48:0]        mem [DEPTH];
    logic [48:0]        head;
    logic               push, pop;

    // Redirect beats both a pop and a push in the same cycle.
    always_comb begin
        push       = (state_reg == FETCH) && rom_ack && !redir;
        pop        = valid && ready && !redir;
        count_next = count_reg;
        if (redir)
            count_next = '0;
        else if (push && !pop)
            count_next = count_reg + CNT_ONE;
        else if (pop && !push)
            count_next = count_reg - CNT_ONE;

        state_next = state_reg;
        addr_next  = addr_reg;
        fp_next    = fp_reg;
        case (state_reg)
            IDLE: begin
                if (redir) begin
                    fp_next    = redir_pc;
                    addr_next  = redir_pc;
                    state_next = FETCH;
                end else if (count_next < FULL_CNT) begin
                    addr_next  = fp_reg;
                    state_next = FETCH;
                end
            end
            FETCH: begin
                if (redir) begin
                    fp_next = redir_pc;
                    if (rom_ack) begin
                        addr_next  = redir_pc;
                        state_next = FETCH;
                    end else begin
                        // Stale request stays on the bus until its ack is swallowed.
                        state_next = DROP;
                    end
                end else if (rom_ack) begin
                    fp_next = addr_reg + 17'd1;
                    if (count_next < FULL_CNT)
                        addr_next = addr_reg + 17'd1;
                    else
                        state_next = IDLE;
                end
            end
            DROP: begin
                if (redir)
                    fp_next = redir_pc;
                if (rom_ack) begin
                    addr_next  = redir ? redir_pc : fp_reg;
                    state_next = FETCH;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            addr_reg   <= RESET_PC;
            fp_reg     <= RESET_PC;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            fp_reg    <= fp_next;
            count_reg <= count_next;
            if (redir) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
            end else begin
                if (push)
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                if (pop)
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {addr_reg, rom_data};
    end

    // Head is gated so the outputs read zero whenever the buffer is empty.
    assign head     = mem[rd_ptr_reg];
    assign valid    = (count_reg != '0);
    assign raw      = valid ? head[31:0]  : 32'h0;
    assign raw_pc   = valid ? head[48:32] : 17'h0;
    assign rom_req  = (state_reg != IDLE);
    assign busy     = (state_reg != IDLE);
    assign rom_addr = addr_reg;

endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of two, 2..16).
REQ-002 SHALL have parameter RESET_PC, default 17'h00000, meaning first fetch word address after reset.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-005 SHALL have port rom_req, output, 1, ROM read request, held until acknowledged.
REQ-006 SHALL have port rom_addr, output, 17, word address of the pending ROM read.
REQ-007 SHALL have port rom_ack, input, 1, one-cycle acknowledge; rom_data valid the same cycle.
REQ-008 SHALL have port rom_data, input, 32, instruction word returned by ROM.
REQ-009 SHALL have port raw, output, 32, head instruction presented to the execution control unit.
REQ-010 SHALL have port raw_pc, output, 17, word address of raw.
REQ-011 SHALL have port valid, output, 1, raw/raw_pc hold a live instruction.
REQ-012 SHALL have port ready, input, 1, consumer accepts head when valid and ready are both high.
REQ-013 SHALL have port redir, input, 1, one-cycle branch/jump redirect strobe.
REQ-014 SHALL have port redir_pc, input, 17, redirect target word address.
REQ-015 SHALL have port busy, output, 1, high while a ROM request is outstanding (FETCH or DROP).

Function
REQ-016 SHALL hold a fetch pointer fp (17 bit), a DEPTH-entry FIFO of {pc,instr} pairs, and count (0..DEPTH).
REQ-017 SHALL implement states IDLE, FETCH, DROP; rom_req = 1 in FETCH and DROP, 0 in IDLE; rom_addr = registered address of the outstanding request.
REQ-018 SHALL allow at most one outstanding ROM request.
REQ-019 IDLE -> FETCH when count after this edge < DEPTH and no redir; the request address is fp.
REQ-020 FETCH with rom_ack and no redir: push {rom_addr, rom_data}, fp <= rom_addr + 1; stay in FETCH if space remains after push/pop this edge, else IDLE.
REQ-021 fp increment SHALL wrap modulo 2^17 (17'h1FFFF + 1 = 17'h00000).
REQ-022 valid = (count != 0); raw/raw_pc = FIFO head; head and count SHALL NOT change while valid & !ready.
REQ-023 Pop and push in the same edge SHALL leave count unchanged with order preserved.
REQ-024 Latency: rom_ack at edge N -> valid high after edge N when FIFO was empty (one-cycle ack-to-valid).
REQ-025 redir SHALL flush the FIFO (count <= 0, valid low after the edge), take precedence over a same-cycle pop, and set fp <= redir_pc.
REQ-026 redir in IDLE, or in FETCH with rom_ack same cycle: discard any returned data; next state FETCH with rom_addr = redir_pc.
REQ-027 redir in FETCH without rom_ack: next state DROP; the stale request keeps its rom_addr and rom_req stays high.
REQ-028 DROP with rom_ack: discard rom_data; next state FETCH with rom_addr = fp.
REQ-029 redir in DROP: update fp to the newer redir_pc; remain DROP (latest redirect wins).
REQ-030 rom_ack while IDLE SHALL be ignored.
REQ-031 FIFO read/write pointers SHALL wrap modulo DEPTH; full = (count == DEPTH), never exceeded.

Reset
REQ-032 On rst low, immediately: state IDLE, rom_req 0, rom_addr RESET_PC, fp RESET_PC, count 0, valid 0, busy 0, raw 0, raw_pc 0.
REQ-033 Reset asserted mid-request SHALL abandon the request; a rom_ack arriving during or after reset for that request SHALL be ignored.
REQ-034 First rising edge with rst high SHALL enter FETCH with rom_addr = RESET_PC.

Verification
REQ-035 Release reset, ROM acks every cycle, ready=1 -> raw_pc sequence 0,1,2,3..., valid continuous from cycle after first ack.
REQ-036 ready=0, ROM acks immediately -> exactly 4 pushes at addrs 0..3, then rom_req 0; ready=1 for one cycle -> one new request at addr 4.
REQ-037 RESET_PC=17'h1FFFE, continuous acks -> raw_pc 1FFFE, 1FFFF, 00000, 00001.
REQ-038 redir to 17'h00100 while FETCH addr 5 outstanding, ack 3 cycles later -> addr-5 data never appears on raw; next rom_addr 100; first valid raw_pc 100.
REQ-039 redir, redir_pc=17'h00040 with rom_ack and ready same cycle, count=2 -> valid low next cycle, no push, rom_addr 040.
REQ-040 rst pulsed low during FETCH addr 7 -> rom_req 0 immediately; after release rom_addr = RESET_PC, count 0.
